// File: rtl/polara_loopback_pattern_gen.sv
// Loopback pattern generator: emits fixed, march or LFSR packets on up to eight
// independent valid/ready NoC channels, with per-channel sequence numbering.
module polara_loopback_pattern_gen #(
    parameter int          NUM_CH    = 3,
    parameter int          DATA_W    = 64,
    parameter int          PKT_FLITS = 4,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2024
) (
    input  logic                     chipset_clk,
    input  logic                     chip_rst_n,
    input  logic [1:0]               mode,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic                     start,
    input  logic                     stop,
    input  logic [15:0]              pkt_limit,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_val,
    input  logic [NUM_CH-1:0]        out_rdy,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_CH*16-1:0]     pkt_cnt
);

    localparam int         MW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [7:0] LAST_IDX = 8'(PKT_FLITS - 1);

    typedef enum logic [1:0] {G_IDLE = 2'd0, G_RUN = 2'd1, G_DRAIN = 2'd2} gstate_t;
    typedef enum logic [1:0] {C_OFF = 2'd0, C_HDR = 2'd1, C_PAY = 2'd2, C_FIN = 2'd3} cstate_t;

    gstate_t           r_gst;
    logic [1:0]        r_mode;
    logic [NUM_CH-1:0] r_en;
    logic [15:0]       r_limit;
    logic [NUM_CH-1:0] w_fin;
    logic              w_all_fin;
    logic              w_launch;
    logic              w_draining;

    // Galois form, bit i of the state holds the x^i coefficient
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0000_0000);
    endfunction

    function automatic logic [DATA_W-1:0] hdr_flit(input logic [15:0] seq, input logic [7:0] ch);
        logic [DATA_W-1:0] f;
        f       = '0;
        f[31:0] = {ch, seq, LAST_IDX};
        return f;
    endfunction

    function automatic logic [DATA_W-1:0] pay_flit(input logic [1:0] md, input logic [MW-1:0] pos,
                                                   input logic [31:0] lf);
        logic [DATA_W-1:0] f;
        f = '0;
        case (md)
            2'b01:   f = {(DATA_W/8){8'hA5}};
            2'b10:   f[pos] = 1'b1;
            2'b11:   f = {(DATA_W/32){lf}};
            default: f = '0;
        endcase
        return f;
    endfunction

    assign w_launch   = (r_gst == G_IDLE) && start && (mode != 2'b00) && (ch_en != '0);
    // A stop seen in RUN already steers channels on the same edge the FSM enters DRAIN
    assign w_draining = (r_gst == G_DRAIN) || ((r_gst == G_RUN) && stop);
    assign w_all_fin  = &w_fin;

    // Global run FSM with sampled run settings, busy and done
    always_ff @(posedge chipset_clk or negedge chip_rst_n) begin
        if (!chip_rst_n) begin
            r_gst   <= G_IDLE;
            r_mode  <= 2'b00;
            r_en    <= '0;
            r_limit <= 16'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_gst)
                G_IDLE: begin
                    if (w_launch) begin
                        r_gst   <= G_RUN;
                        r_mode  <= mode;
                        r_en    <= ch_en;
                        r_limit <= pkt_limit;
                        busy    <= 1'b1;
                    end
                end
                G_RUN: begin
                    if (w_all_fin) begin
                        r_gst <= G_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (stop) begin
                        r_gst <= G_DRAIN;
                    end
                end
                G_DRAIN: begin
                    if (w_all_fin) begin
                        r_gst <= G_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    r_gst <= G_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        cstate_t           r_cst;
        logic [15:0]       r_seq;
        logic [15:0]       r_cnt;
        logic [7:0]        r_idx;
        logic [MW-1:0]     r_pos;
        logic [31:0]       r_lfsr;
        logic [DATA_W-1:0] r_data;
        logic              r_val;
        logic              w_xfer;
        logic [MW-1:0]     w_pos_nxt;
        logic [31:0]       w_lfsr_nxt;
        logic [15:0]       w_cnt_nxt;

        assign w_xfer     = r_val & out_rdy[c];
        assign w_pos_nxt  = (r_pos == MW'(DATA_W - 1)) ? '0 : r_pos + 1'b1;
        assign w_lfsr_nxt = lfsr_step(r_lfsr);
        assign w_cnt_nxt  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
        assign w_fin[c]   = (r_cst == C_FIN) || !r_en[c];

        assign out_data[c*DATA_W +: DATA_W] = r_data;
        assign out_val[c]                   = r_val;
        assign pkt_cnt[c*16 +: 16]          = r_cnt;

        // Per-channel packet sequencer; the next flit is registered as the current one transfers
        always_ff @(posedge chipset_clk or negedge chip_rst_n) begin
            if (!chip_rst_n) begin
                r_cst  <= C_OFF;
                r_seq  <= 16'd0;
                r_cnt  <= 16'd0;
                r_idx  <= 8'd0;
                r_pos  <= '0;
                r_lfsr <= 32'd0;
                r_data <= '0;
                r_val  <= 1'b0;
            end else if (w_launch) begin
                r_cst  <= C_OFF;
                r_seq  <= 16'd0;
                r_cnt  <= 16'd0;
                r_idx  <= 8'd0;
                r_pos  <= '0;
                r_lfsr <= LFSR_SEED ^ 32'(c);
                r_data <= '0;
                r_val  <= 1'b0;
            end else if (r_gst == G_IDLE) begin
                r_cst <= C_OFF;
                r_val <= 1'b0;
            end else begin
                case (r_cst)
                    C_OFF: begin
                        if (r_en[c]) begin
                            if (w_draining) begin
                                r_cst <= C_FIN;
                            end else begin
                                r_cst  <= C_HDR;
                                r_val  <= 1'b1;
                                r_data <= hdr_flit(r_seq, 8'(c));
                            end
                        end
                    end
                    C_HDR: begin
                        if (w_xfer) begin
                            r_cst  <= C_PAY;
                            r_idx  <= 8'd1;
                            r_data <= pay_flit(r_mode, r_pos, r_lfsr);
                        end else if (w_draining) begin
                            r_cst <= C_FIN;
                            r_val <= 1'b0;
                        end
                    end
                    C_PAY: begin
                        if (w_xfer) begin
                            r_pos  <= w_pos_nxt;
                            r_lfsr <= w_lfsr_nxt;
                            if (r_idx == LAST_IDX) begin
                                r_cnt <= w_cnt_nxt;
                                r_seq <= r_seq + 16'd1;
                                r_idx <= 8'd0;
                                if (((r_limit != 16'd0) && (w_cnt_nxt == r_limit)) || w_draining) begin
                                    r_cst <= C_FIN;
                                    r_val <= 1'b0;
                                end else begin
                                    r_cst  <= C_HDR;
                                    r_data <= hdr_flit(r_seq + 16'd1, 8'(c));
                                end
                            end else begin
                                r_idx  <= r_idx + 8'd1;
                                r_data <= pay_flit(r_mode, w_pos_nxt, w_lfsr_nxt);
                            end
                        end
                    end
                    C_FIN: begin
                        r_val <= 1'b0;
                    end
                    default: begin
                        r_cst <= C_OFF;
                        r_val <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/polara_loopback_pattern_gen.md
POLARA_LOOPBACK_PATTERN_GEN -- requirements
Module: polara_loopback_pattern_gen

Interface
REQ-001 Parameter NUM_CH, default 3, number of independent NoC output channels (1..8).
REQ-002 Parameter DATA_W, default 64, flit width; multiple of 32, minimum 32.
REQ-003 Parameter PKT_FLITS, default 4, flits per packet including the header (2..255).
REQ-004 Parameter LFSR_SEED, default 32'hACE1_2024, nonzero base seed for LFSR mode.
REQ-005 chipset_clk  in  1  sole clock; all logic rising-edge.
REQ-006 chip_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 mode  in  2  00 idle, 01 fixed, 10 march, 11 lfsr.
REQ-008 ch_en  in  NUM_CH  per-channel enable mask.
REQ-009 start  in  1  one-cycle run request.
REQ-010 stop  in  1  one-cycle request to end the run after the current packets.
REQ-011 pkt_limit  in  16  packets per enabled channel; 0 = unlimited.
REQ-012 out_data  out  NUM_CH*DATA_W  flit data, channel c at bits [c*DATA_W +: DATA_W].
REQ-013 out_val  out  NUM_CH  per-channel valid.
REQ-014 out_rdy  in  NUM_CH  per-channel ready from the chip interface.
REQ-015 busy  out  1  run in progress.
REQ-016 done  out  1  one-cycle pulse at run completion.
REQ-017 pkt_cnt  out  NUM_CH*16  packets fully accepted per channel in the current run.

Function
REQ-018 Global FSM states IDLE, RUN, DRAIN; per-channel FSM states OFF, HDR, PAY, FIN.
REQ-019 IDLE: start with mode!=00 and ch_en!=0 samples mode, ch_en and pkt_limit, zeroes pkt_cnt and sequence numbers, and enters RUN; any other start is ignored.
REQ-020 Sampled settings hold for the whole run; changes to mode, ch_en and pkt_limit mid-run are ignored; start while busy is ignored.
REQ-021 Latency: start sampled at edge N -> out_val high with the header flit after edge N+1 on every enabled channel; disabled channels stay OFF with out_val=0.
REQ-022 Handshake: a flit transfers on a rising edge where out_val&out_rdy; while out_val&!out_rdy, out_data and out_val hold stable; out_val never drops without a transfer.
REQ-023 Back-to-back: with out_rdy held high, a channel issues one flit per cycle with no bubbles, including across packet boundaries.
REQ-024 Header flit: bits[7:0]=PKT_FLITS-1, [23:8]=16-bit per-channel sequence number (starts 0, +1 per packet, wraps at 16'hFFFF), [31:24]=channel index, remaining bits 0.
REQ-025 Fixed payload: every byte 8'hA5.
REQ-026 March payload: single one-hot bit at position w mod DATA_W; w starts 0 per run and increments per accepted payload flit, continuing across packets.
REQ-027 LFSR payload: 32-bit Galois LFSR, taps x^32+x^22+x^2+x+1, seeded LFSR_SEED^c at run start, stepping once per accepted payload flit, value replicated across DATA_W.
REQ-028 pkt_cnt increments on acceptance of the last flit of a packet and saturates at 16'hFFFF.
REQ-029 Channel enters FIN when pkt_cnt reaches a nonzero pkt_limit; a stop received in RUN enters DRAIN, in which every channel finishes its current packet then enters FIN, and channels in HDR with no flit yet accepted go straight to FIN.
REQ-030 stop and start on the same cycle in IDLE: start wins; stop in IDLE is ignored.
REQ-031 When all enabled channels are FIN: done pulses for exactly one cycle, busy falls on the same edge, FSM returns to IDLE, pkt_cnt is retained until the next start.
REQ-032 busy is high from the edge after an accepted start until the done edge.

Reset
REQ-033 chip_rst_n low immediately clears out_val, out_data, busy, done, pkt_cnt, sequence numbers, march index and LFSR state, and forces IDLE/OFF, including mid-packet.
REQ-034 After reset deassertion, no flit issues until a new start.

Verification
REQ-035 Reset: hold chip_rst_n=0 for 2 cycles -> all outputs 0, busy=0.
REQ-036 Fixed mode, ch_en=001, pkt_limit=2, out_rdy=111 -> ch0 emits 8 consecutive flits: headers 64'h0000_0003 then 64'h0000_0103, payload 64'hA5A5_A5A5_A5A5_A5A5; done pulses once; pkt_cnt[15:0]=2; ch1/ch2 out_val stay 0.
REQ-037 Backpressure: ch0 out_rdy=0 for 5 cycles while a header is presented -> out_val=1 and out_data unchanged for all 5 cycles; transfer on the first cycle with out_rdy=1.
REQ-038 March, ch_en=010, pkt_limit=2 -> ch1 payloads 0x1, 0x2, 0x4, then 0x8, 0x10, 0x20; header bits[31:24]=1.
REQ-039 Unlimited run (pkt_limit=0), stop asserted during the 2nd payload flit -> packet completes, then done pulses, and pkt_cnt equals the number of packets whose last flit was accepted.
REQ-040 Reset mid-packet, then start -> out_val drops asynchronously; the next header carries sequence number 0.
